// File: rtl/clock_set_controller_if.sv
// Bus bundle for clock_set_controller: button pulses in, time/state out.
// Optional alarm output is present only when CLOCK_ALARM_EN is defined.
// Handshake: mode_btn/inc_btn are single-cycle pulses with no ready/ack;
// every pulse sampled high on a rising clk edge is consumed on that edge.
interface clock_set_controller_if;
    logic       mode_btn;
    logic       inc_btn;
    logic       sec_tick;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic [2:0] state;
`ifdef CLOCK_ALARM_EN
    logic       alarm_hit;

    modport master (output mode_btn, output inc_btn,
                    input sec_tick, input seconds, input minutes,
                    input hours, input state, input alarm_hit);
    modport slave  (input mode_btn, input inc_btn,
                    output sec_tick, output seconds, output minutes,
                    output hours, output state, output alarm_hit);
`else
    modport master (output mode_btn, output inc_btn,
                    input sec_tick, input seconds, input minutes,
                    input hours, input state);
    modport slave  (input mode_btn, input inc_btn,
                    output sec_tick, output seconds, output minutes,
                    output hours, output state);
`endif
endinterface

// File: rtl/clock_set_controller.sv
// 24-hour clock with button-driven time setting.
// Define CLOCK_ALARM_EN to add the ALM_HR/ALM_MIN states, the alarm
// registers and the alarm_hit pulse.
module clock_set_controller #(
    parameter int TICK_DIV = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    clock_set_controller_if.slave   bus
);
    localparam logic [2:0]  ST_RUN     = 3'd0;
    localparam logic [2:0]  ST_SET_HR  = 3'd1;
    localparam logic [2:0]  ST_SET_MIN = 3'd2;
    localparam logic [2:0]  ST_ALM_HR  = 3'd3;
    localparam logic [2:0]  ST_ALM_MIN = 3'd4;
    localparam logic [23:0] LP_PRESC_LAST = 24'(TICK_DIV - 1);

    logic [2:0]  r_state;
    logic [23:0] r_presc;
    logic [5:0]  r_sec;
    logic [5:0]  r_min;
    logic [4:0]  r_hr;

    logic        w_run;
    logic        w_tick;
    logic        w_set_exit;
    logic        w_inc;
    logic [2:0]  w_adv_state;
    logic [5:0]  w_next_sec;
    logic [5:0]  w_next_min;
    logic [4:0]  w_next_hr;

    assign w_run      = (r_state == ST_RUN);
    assign w_tick     = w_run && (r_presc == LP_PRESC_LAST);
    // Leaving SET_MIN restarts the second so the new time starts on a boundary.
    assign w_set_exit = bus.mode_btn && (r_state == ST_SET_MIN);
    // mode_btn wins over a coincident inc_btn.
    assign w_inc      = bus.inc_btn && !bus.mode_btn;

    // Time value after one second elapses, with sec/min/hour carries.
    always_comb begin
        w_next_sec = r_sec + 6'd1;
        w_next_min = r_min;
        w_next_hr  = r_hr;
        if (r_sec == 6'd59) begin
            w_next_sec = 6'd0;
            w_next_min = r_min + 6'd1;
            if (r_min == 6'd59) begin
                w_next_min = 6'd0;
                w_next_hr  = (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
            end
        end
    end

    // Successor state selected by a mode_btn press.
    always_comb begin
        w_adv_state = ST_RUN;
        case (r_state)
            ST_RUN:     w_adv_state = ST_SET_HR;
            ST_SET_HR:  w_adv_state = ST_SET_MIN;
`ifdef CLOCK_ALARM_EN
            ST_SET_MIN: w_adv_state = ST_ALM_HR;
            ST_ALM_HR:  w_adv_state = ST_ALM_MIN;
            ST_ALM_MIN: w_adv_state = ST_RUN;
`else
            ST_SET_MIN: w_adv_state = ST_RUN;
`endif
            default:    w_adv_state = ST_RUN;
        endcase
    end

    // Set-mode state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_RUN;
        else if (bus.mode_btn)
            r_state <= w_adv_state;
    end

    // Prescaler: counts only in RUN, wraps on the tick, cleared on set exit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_presc <= 24'd0;
        else if (w_set_exit)
            r_presc <= 24'd0;
        else if (w_run)
            r_presc <= w_tick ? 24'd0 : r_presc + 24'd1;
    end

    // Time-of-day registers: advance on tick in RUN, edited in set states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec <= 6'd0;
            r_min <= 6'd0;
            r_hr  <= 5'd0;
        end else if (w_tick) begin
            r_sec <= w_next_sec;
            r_min <= w_next_min;
            r_hr  <= w_next_hr;
        end else if (w_set_exit) begin
            r_sec <= 6'd0;
        end else if (w_inc && (r_state == ST_SET_HR)) begin
            r_hr  <= (r_hr == 5'd23) ? 5'd0 : r_hr + 5'd1;
        end else if (w_inc && (r_state == ST_SET_MIN)) begin
            r_min <= (r_min == 6'd59) ? 6'd0 : r_min + 6'd1;
        end
    end

`ifdef CLOCK_ALARM_EN
    logic [4:0] r_alm_hr;
    logic [5:0] r_alm_min;

    // Alarm time registers, edited in the ALM states with the same wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alm_hr  <= 5'd0;
            r_alm_min <= 6'd0;
        end else if (w_inc && (r_state == ST_ALM_HR)) begin
            r_alm_hr  <= (r_alm_hr == 5'd23) ? 5'd0 : r_alm_hr + 5'd1;
        end else if (w_inc && (r_state == ST_ALM_MIN)) begin
            r_alm_min <= (r_alm_min == 6'd59) ? 6'd0 : r_alm_min + 6'd1;
        end
    end

    // Fires on the tick whose edge lands exactly on alarm HH:MM:00.
    assign bus.alarm_hit = w_tick && (w_next_sec == 6'd0) &&
                           (w_next_min == r_alm_min) && (w_next_hr == r_alm_hr);
`endif

    assign bus.sec_tick = w_tick;
    assign bus.seconds  = r_sec;
    assign bus.minutes  = r_min;
    assign bus.hours    = r_hr;
    assign bus.state    = r_state;
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with TICK_DIV=4.
// Define CLOCK_ALARM_EN to also exercise the alarm path.
module tb_clock_set_controller;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   n_tick;
    int   first_k;
    int   n_hit;
    int   hit_k;
    int   tick_at_hit;

    clock_set_controller_if bus ();

    clock_set_controller #(.TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock: 10-time-unit period; inputs change and outputs are sampled on negedge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One-cycle button pulse; returns at the negedge after the capturing edge.
    task automatic press(input logic m, input logic i);
        bus.mode_btn = m;
        bus.inc_btn  = i;
        @(negedge clk);
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
    endtask

    task automatic inc_n(input int n);
        for (int j = 0; j < n; j++) begin
            press(1'b0, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.mode_btn = 1'b0;
        bus.inc_btn  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", bus.state, 0);
        check("rst_sec", bus.seconds, 0);
        check("rst_min", bus.minutes, 0);
        check("rst_hr", bus.hours, 0);
        check("rst_tick", bus.sec_tick, 0);
`ifdef CLOCK_ALARM_EN
        check("rst_alarm_hit", bus.alarm_hit, 0);
`endif
        rst = 1'b0;

        // Free run 240 cycles: 60 ticks, first tick in the cycle after the 3rd edge.
        n_tick = 0;
        first_k = -1;
        for (int k = 1; k <= 240; k++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) begin
                n_tick++;
                if (first_k < 0) first_k = k;
            end
        end
        check("first_tick_edge", first_k, 3);
        check("ticks_240", n_tick, 60);
        check("run240_sec", bus.seconds, 0);
        check("run240_min", bus.minutes, 1);
        check("run240_hr", bus.hours, 0);

        // mode and inc together in RUN: state advances, inc dropped.
        press(1'b1, 1'b1);
        check("same_cycle_state", bus.state, 1);
        check("same_cycle_hr", bus.hours, 0);

        // Time frozen in SET_HR.
        n_tick = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (bus.sec_tick !== 1'b0) n_tick++;
        end
        check("set_hr_no_tick", n_tick, 0);
        check("set_hr_sec_held", bus.seconds, 0);

        press(1'b1, 1'b0);
        check("to_set_min", bus.state, 2);
        inc_n(36);
        check("min_37", bus.minutes, 37);

        // Asynchronous reset between clock edges while in SET_MIN.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", bus.state, 0);
        check("async_rst_min", bus.minutes, 0);
        check("async_rst_sec", bus.seconds, 0);
        check("async_rst_hr", bus.hours, 0);
        check("async_rst_tick", bus.sec_tick, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Hours wrap through 24 presses, minutes through 61.
        press(1'b1, 1'b0);
        check("enter_set_hr", bus.state, 1);
        inc_n(25);
        check("hr_inc25", bus.hours, 1);
        press(1'b1, 1'b0);
        check("enter_set_min", bus.state, 2);
        inc_n(61);
        check("min_inc61", bus.minutes, 1);
        check("min_no_carry_hr", bus.hours, 1);
        press(1'b1, 1'b0);
        check("exit_state", bus.state, 0);
        check("exit_sec", bus.seconds, 0);
        check("exit_tick", bus.sec_tick, 0);
        repeat (3) @(negedge clk);
        check("exit_first_tick", bus.sec_tick, 1);
        check("exit_sec_before", bus.seconds, 0);
        @(negedge clk);
        check("exit_sec_after", bus.seconds, 1);
        check("exit_tick_low", bus.sec_tick, 0);

        // Preload 23:59:xx through set mode, including single-step wraps.
        press(1'b1, 1'b0);
        check("preload_set_hr", bus.state, 1);
        inc_n(22);
        check("hr_23", bus.hours, 23);
        inc_n(1);
        check("hr_wrap_0", bus.hours, 0);
        inc_n(23);
        press(1'b1, 1'b0);
        inc_n(58);
        check("min_59", bus.minutes, 59);
        inc_n(1);
        check("min_wrap_0", bus.minutes, 0);
        check("min_wrap_hr_kept", bus.hours, 23);
        inc_n(59);
        press(1'b1, 1'b0);
        check("preload_run", bus.state, 0);
        check("preload_hms", {bus.hours, bus.minutes, bus.seconds}, {5'd23, 6'd59, 6'd0});

        n_tick = 0;
        for (int k = 0; k < 236; k++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) n_tick++;
        end
        check("ticks_to_59", n_tick, 59);
        check("at_235959", {bus.hours, bus.minutes, bus.seconds}, {5'd23, 6'd59, 6'd59});
        n_tick = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (bus.sec_tick === 1'b1) n_tick++;
        end
        check("midnight_ticks", n_tick, 1);
        check("midnight_hms", {bus.hours, bus.minutes, bus.seconds}, 17'd0);

`ifdef CLOCK_ALARM_EN
        // Alarm at 00:02 fires once, on the tick that reaches 00:02:00.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("alm_hr_state", bus.state, 3);
        press(1'b1, 1'b0);
        check("alm_min_state", bus.state, 4);
        inc_n(2);
        press(1'b1, 1'b0);
        check("alm_exit_state", bus.state, 0);
        n_hit = 0;
        hit_k = -1;
        tick_at_hit = 0;
        for (int k = 1; k <= 480; k++) begin
            @(negedge clk);
            if (bus.alarm_hit === 1'b1) begin
                n_hit++;
                hit_k = k;
                tick_at_hit = int'(bus.sec_tick);
            end
        end
        check("alarm_hits", n_hit, 1);
        check("alarm_hit_cycle", hit_k, 479);
        check("alarm_with_tick", tick_at_hit, 1);
        check("alarm_time", {bus.hours, bus.minutes, bus.seconds}, {5'd0, 6'd2, 6'd0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clock_set_controller.md
CLOCK_SET_CONTROLLER -- requirements
Module: clock_set_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100, meaning clk cycles per second tick; legal range 2..2^24.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port mode_btn  input  1  single-cycle pulse, pre-debounced; advances the set-mode state machine.
REQ-005 SHALL have port inc_btn  input  1  single-cycle pulse, pre-debounced; increments the field currently selected for setting.
REQ-006 SHALL have port sec_tick  output  1  one-cycle pulse, once per second, asserted only while running.
REQ-007 SHALL have port seconds  output  6  current seconds, 0..59.
REQ-008 SHALL have port minutes  output  6  current minutes, 0..59.
REQ-009 SHALL have port hours  output  5  current hours, 0..23.
REQ-010 SHALL have port state  output  3  current state encoding: RUN=0, SET_HR=1, SET_MIN=2, ALM_HR=3, ALM_MIN=4.

Function
REQ-011 SHALL count a prescaler 0..TICK_DIV-1 in RUN; sec_tick=1 in the cycle the prescaler equals TICK_DIV-1, and the prescaler wraps to 0 in that cycle.
REQ-012 SHALL, on the clk edge ending a sec_tick cycle, advance seconds by 1; seconds 59 -> 0 with minutes +1; minutes 59 with seconds 59 -> 0 with hours +1; 23:59:59 -> 00:00:00.
REQ-013 SHALL, in SET_HR and SET_MIN, hold the prescaler and seconds, and keep sec_tick=0.
REQ-014 SHALL implement these transitions on mode_btn: RUN->SET_HR, SET_HR->SET_MIN, SET_MIN->RUN (macro off) or SET_MIN->ALM_HR (macro on), ALM_HR->ALM_MIN, ALM_MIN->RUN.
REQ-015 SHALL, on inc_btn, increment in SET_HR: hours (23->0); in SET_MIN: minutes (59->0), with no carry into hours; in RUN: no effect.
REQ-016 SHALL clear seconds and the prescaler to 0 on the SET_MIN->RUN or SET_MIN->ALM_HR transition.
REQ-017 SHALL give mode_btn priority when mode_btn and inc_btn arrive in the same cycle: the state advances and inc_btn is discarded.
REQ-018 SHALL update outputs with one-cycle latency: a button pulse in cycle N is visible in the outputs at cycle N+1.
REQ-019 SHALL never let any output field leave its legal range.

Reset
REQ-020 SHALL, on rst=1 and regardless of clk, force state=RUN, seconds=0, minutes=0, hours=0, prescaler=0, and sec_tick=0, plus alarm registers=0 and alarm_hit=0 if present.
REQ-021 SHALL restart from REQ-020 values when reset is asserted mid-set or mid-tick, with no partial update retained.
REQ-022 SHALL begin counting on the first clk edge after rst deasserts; the first sec_tick occurs TICK_DIV cycles after release.

Configuration
REQ-023 SHALL compile alarm support in only when macro CLOCK_ALARM_EN is defined.
REQ-024 With CLOCK_ALARM_EN defined, SHALL add output alarm_hit (1 bit) and internal alarm_hours (5 bits) and alarm_minutes (6 bits), set in ALM_HR/ALM_MIN via inc_btn with the same wrap rules as REQ-015.
REQ-025 With CLOCK_ALARM_EN defined, SHALL pulse alarm_hit for exactly one cycle, coincident with the sec_tick that makes the time alarm_hours:alarm_minutes:00, in RUN only.
REQ-026 Without CLOCK_ALARM_EN, SHALL omit alarm_hit and the ALM states; encodings 3 and 4 are unreachable.

Verification (TICK_DIV=4)
REQ-027 SHALL cover: reset, then 240 clk cycles -> 60 sec_tick pulses, seconds=0, minutes=1, hours=0.
REQ-028 SHALL cover: preload 23:59:59 via set mode, then 4 clk cycles -> 00:00:00 with a single sec_tick.
REQ-029 SHALL cover: mode_btn, then inc_btn x25 -> hours=1; mode_btn, then inc_btn x61 -> minutes=1 and hours stays 1; mode_btn -> state=RUN, seconds=0.
REQ-030 SHALL cover: mode_btn and inc_btn in the same cycle while in RUN -> state=SET_HR and hours unchanged.
REQ-031 SHALL cover: rst pulsed mid-cycle while in SET_MIN with minutes=37 -> immediately state=RUN and all fields 0, with no clk edge required.
REQ-032 SHALL cover, with CLOCK_ALARM_EN: alarm set to 00:02, run 480 cycles -> a single alarm_hit pulse aligned with the tick reaching 00:02:00.
